// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue/writeback controller.
// Build option: DIV_ZERO_FAST_EN (see div_issue_ctrl.sv).
package div_issue_ctrl_pkg;

    // Divider pipeline depth; sets the default issue-to-result latency.
    localparam int DIV_PPL_STAGE = 8;

    localparam logic DIV_TYPE_SIGNED   = 1'b1;
    localparam logic DIV_TYPE_QUOTIENT = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } div_state_e;

    // Register usage of the instruction currently in ID.
    typedef struct packed {
        logic [4:0] rs1;
        logic       rs1_re;
        logic [4:0] rs2;
        logic       rs2_re;
        logic [4:0] rd;
        logic       rd_we;
    } id_regs_t;

    function automatic logic reg_match(input logic en, input logic [4:0] a, input logic [4:0] b);
        return en && (a == b);
    endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Handshake/bus bundle between ID/EX, the divider datapath and the issue controller.
interface div_issue_ctrl_if;

    logic        ex_div_req;
    logic        ex_flush;
    logic        ex_sign;
    logic        ex_rem;
    logic [4:0]  ex_rd;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_re;
    logic        id_rs2_re;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        pipe_wb_we;
    logic [31:0] div_result;

    logic        div_start;
    logic        div_sign;
    logic        div_rem;
    logic        div_wb_we;
    logic [4:0]  div_wb_addr;
    logic [31:0] div_wb_data;
    logic        busy;
    logic        stall_req;

    // Pipeline / divider side.
    modport master (
        output ex_div_req, ex_flush, ex_sign, ex_rem, ex_rd, ex_op_a, ex_op_b,
        output id_rs1, id_rs2, id_rs1_re, id_rs2_re, id_rd, id_rd_we,
        output pipe_wb_we, div_result,
        input  div_start, div_sign, div_rem, div_wb_we, div_wb_addr, div_wb_data,
        input  busy, stall_req
    );

    // Controller side.
    modport slave (
        input  ex_div_req, ex_flush, ex_sign, ex_rem, ex_rd, ex_op_a, ex_op_b,
        input  id_rs1, id_rs2, id_rs1_re, id_rs2_re, id_rd, id_rd_we,
        input  pipe_wb_we, div_result,
        output div_start, div_sign, div_rem, div_wb_we, div_wb_addr, div_wb_data,
        output busy, stall_req
    );

endinterface

// File: rtl/div_issue_ctrl_hazard_cmp.sv
// Compares the ID instruction's register usage against the divider's pending destination.
module div_hazard_cmp
    import div_issue_ctrl_pkg::*;
(
    input  logic       pend_vld,
    input  logic [4:0] pend_rd,
    input  id_regs_t   id,
    output logic       hazard
);

    // x0 is never a real dependency.
    assign hazard = pend_vld && (pend_rd != 5'd0) &&
                    (reg_match(id.rs1_re, id.rs1, pend_rd) ||
                     reg_match(id.rs2_re, id.rs2, pend_rd) ||
                     reg_match(id.rd_we,  id.rd,  pend_rd));

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/writeback scheduler for the pipelined divider: one divide in flight, RAW/WAW/structural stalls.
// Build option: DIV_ZERO_FAST_EN resolves divide-by-zero at issue without starting the divider.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DIV_LAT = DIV_PPL_STAGE,
    parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
    input logic             clk,
    input logic             rst,
    div_issue_ctrl_if.slave bus
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       pend_rd;
    logic [31:0]      buf_q;
    logic             rem_q;

    logic req_live, issue, zero_fast;
    logic res_vld, wb_busy, wb_hold, wb_we;
    logic structural, hazard;
    logic pend_vld;
    logic [4:0] cmp_rd;
    id_regs_t id_regs;

    // A divide into x0 is a NOP: it never issues, stalls or writes.
    assign req_live = bus.ex_div_req && !bus.ex_flush && (bus.ex_rd != 5'd0);
    assign issue    = (state == ST_IDLE) && req_live;

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast = issue && (bus.ex_op_b == 32'd0);
`else
    assign zero_fast = 1'b0;
`endif

    assign res_vld = (state == ST_BUSY) && (cnt == CNT_W'(1));
    assign wb_busy = res_vld && !bus.pipe_wb_we;
    assign wb_hold = (state == ST_HOLD) && !bus.pipe_wb_we;
    assign wb_we   = wb_busy || wb_hold;

    // The issuing instruction already counts as pending, so compare against ex_rd then.
    assign pend_vld = issue || (state != ST_IDLE);
    assign cmp_rd   = (state == ST_IDLE) ? bus.ex_rd : pend_rd;
    assign id_regs  = '{rs1: bus.id_rs1, rs1_re: bus.id_rs1_re,
                        rs2: bus.id_rs2, rs2_re: bus.id_rs2_re,
                        rd:  bus.id_rd,  rd_we:  bus.id_rd_we};

    div_hazard_cmp u_hazard (
        .pend_vld (pend_vld),
        .pend_rd  (cmp_rd),
        .id       (id_regs),
        .hazard   (hazard)
    );

    assign structural = req_live && (state != ST_IDLE);

    assign bus.div_start   = issue && !zero_fast;
    assign bus.div_sign    = bus.div_start && bus.ex_sign;
    assign bus.div_rem     = rem_q;
    assign bus.div_wb_we   = wb_we;
    assign bus.div_wb_addr = wb_we ? pend_rd : 5'd0;
    assign bus.div_wb_data = wb_busy ? bus.div_result :
                             wb_hold ? buf_q : 32'd0;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.stall_req   = structural || hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend_rd <= 5'd0;
            buf_q   <= 32'd0;
            rem_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (issue) begin
                        pend_rd <= bus.ex_rd;
                        rem_q   <= bus.ex_rem;
                        if (zero_fast) begin
                            buf_q <= bus.ex_rem ? bus.ex_op_a : 32'hFFFF_FFFF;
                            state <= ST_HOLD;
                        end else begin
                            cnt   <= CNT_W'(DIV_LAT);
                            state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    // Pipeline owns the write port this cycle: park the result.
                    if (res_vld) begin
                        if (bus.pipe_wb_we) begin
                            buf_q <= bus.div_result;
                            state <= ST_HOLD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    cnt <= '0;
                    if (!bus.pipe_wb_we)
                        state <= ST_IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    a_port_excl: assert property (@(posedge clk) disable iff (rst)
                                  !(bus.div_wb_we && bus.pipe_wb_we));
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
                                  cnt <= CNT_W'(DIV_LAT));

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized + directed bench for div_issue_ctrl against a deadline-based reference model.
module tb_div_issue_ctrl;

    localparam int DIV_LAT = 8;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_issue_ctrl_if bus ();

    div_issue_ctrl #(.DIV_LAT(DIV_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: one pending destination with a write deadline.
    bit          m_vld = 0;
    logic [4:0]  m_rd;
    int          m_due;
    logic [31:0] m_val;
    logic        m_rem = 0;

    // External divider model slot.
    bit          s_vld = 0;
    int          s_due;
    logic [31:0] s_val;

    int          wb_cnt = 0, start_cnt = 0, stall_cnt = 0;
    int          last_wb_cyc = -1, last_start_cyc = -1;
    logic [31:0] last_wb_data = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic rem);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : a;
        if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
        return rem ? a % b : a / b;
    endfunction

    task automatic idle_inputs();
        bus.ex_div_req = 0; bus.ex_flush = 0; bus.ex_sign = 0; bus.ex_rem = 0;
        bus.ex_rd = 0; bus.ex_op_a = 0; bus.ex_op_b = 0;
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_re = 0; bus.id_rs2_re = 0;
        bus.id_rd = 0; bus.id_rd_we = 0; bus.pipe_wb_we = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model.
    task automatic step();
        logic live, iss, fz, hv, haz, e_wb;
        logic [4:0] hrd;
        bus.div_result = (s_vld && cyc == s_due) ? s_val : $urandom;
        @(negedge clk);
        live = bus.ex_div_req && !bus.ex_flush && bus.ex_rd != 5'd0;
        iss  = !m_vld && live;
        fz   = FAST && iss && bus.ex_op_b == 32'd0;
        hv   = m_vld || iss;
        hrd  = m_vld ? m_rd : bus.ex_rd;
        haz  = hv && hrd != 5'd0 &&
               ((bus.id_rs1_re && bus.id_rs1 == hrd) ||
                (bus.id_rs2_re && bus.id_rs2 == hrd) ||
                (bus.id_rd_we  && bus.id_rd  == hrd));
        e_wb = m_vld && cyc >= m_due && !bus.pipe_wb_we;

        chk("start",   bus.div_start,   iss && !fz);
        chk("sign",    bus.div_sign,    iss && !fz && bus.ex_sign);
        chk("rem",     bus.div_rem,     m_rem);
        chk("busy",    bus.busy,        m_vld);
        chk("stall",   bus.stall_req,   (live && m_vld) || haz);
        chk("wb_we",   bus.div_wb_we,   e_wb);
        chk("wb_addr", bus.div_wb_addr, e_wb ? m_rd : 5'd0);
        chk("wb_data", bus.div_wb_data, e_wb ? m_val : 32'd0);

        if (bus.div_start) begin
            s_vld = 1; s_due = cyc + DIV_LAT;
            s_val = div_ref(bus.ex_op_a, bus.ex_op_b, bus.ex_sign, bus.ex_rem);
            start_cnt++; last_start_cyc = cyc;
        end
        if (bus.div_wb_we) begin
            wb_cnt++; last_wb_cyc = cyc; last_wb_data = bus.div_wb_data;
        end
        if (bus.stall_req) stall_cnt++;

        if (e_wb) m_vld = 0;
        if (iss) begin
            m_vld = 1; m_rd = bus.ex_rd; m_rem = bus.ex_rem;
            m_due = cyc + (fz ? 1 : DIV_LAT);
            m_val = div_ref(bus.ex_op_a, bus.ex_op_b, bus.ex_sign, bus.ex_rem);
        end
        if (rst) begin m_vld = 0; m_rem = 0; end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present one divide for a single cycle, then drop the request.
    task automatic issue_one(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                             input logic sgn, input logic rem);
        bus.ex_div_req = 1; bus.ex_rd = rd; bus.ex_op_a = a; bus.ex_op_b = b;
        bus.ex_sign = sgn; bus.ex_rem = rem;
        step();
        bus.ex_div_req = 0;
    endtask

    initial begin
        int t0, w0, s0, st0;
        idle_inputs();
        bus.div_result = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_busy",  bus.busy, 0);
        chk("rst_rem",   bus.div_rem, 0);
        chk("rst_wb_we", bus.div_wb_we, 0);
        chk("rst_stall", bus.stall_req, 0);

        // 1: DIVU x5 = 100/7, write port free.
        w0 = wb_cnt; t0 = cyc;
        issue_one(5, 100, 7, 0, 0);
        run(12);
        chk("t1_start_cyc", last_start_cyc - t0, 0);
        chk("t1_wb_lat",    last_wb_cyc - t0, DIV_LAT);
        chk("t1_wb_data",   last_wb_data, 14);
        chk("t1_wb_cnt",    wb_cnt - w0, 1);

        // 2: same, pipeline owns the port for T+8..T+10.
        w0 = wb_cnt; t0 = cyc;
        issue_one(5, 100, 7, 0, 0);
        for (int i = 0; i < 14; i++) begin
            bus.pipe_wb_we = (cyc >= t0 + 8 && cyc <= t0 + 10);
            step();
        end
        bus.pipe_wb_we = 0;
        chk("t2_wb_lat",  last_wb_cyc - t0, DIV_LAT + 3);
        chk("t2_wb_data", last_wb_data, 14);
        chk("t2_wb_cnt",  wb_cnt - w0, 1);

        // 3: RAW on rs1 stalls through the write cycle; non-matching or disabled sources do not.
        bus.id_rs1 = 5; bus.id_rs1_re = 1;
        st0 = stall_cnt;
        issue_one(5, 40, 6, 0, 0);
        run(11);
        chk("t3_raw_stall", stall_cnt - st0, DIV_LAT + 1);
        bus.id_rs1 = 6;
        st0 = stall_cnt;
        issue_one(5, 40, 6, 0, 0);
        run(11);
        chk("t3_other_reg", stall_cnt - st0, 0);
        bus.id_rs1_re = 0; bus.id_rs2 = 5; bus.id_rs2_re = 0;
        st0 = stall_cnt;
        issue_one(5, 40, 6, 0, 0);
        run(11);
        chk("t3_rs2_off", stall_cnt - st0, 0);
        idle_inputs();

        // 4: back-to-back divides; second waits for the first write.
        t0 = cyc;
        issue_one(7, 32'hFFFF_FFEC, 3, 1, 0);
        s0 = start_cnt; st0 = stall_cnt;
        bus.ex_div_req = 1; bus.ex_rd = 8; bus.ex_op_a = 50; bus.ex_op_b = 5;
        bus.ex_sign = 0; bus.ex_rem = 0;
        for (int i = 0; i < 40 && start_cnt == s0; i++) step();
        bus.ex_div_req = 0;
        chk("t4_second_issued", start_cnt - s0, 1);
        chk("t4_issue_gap",     last_start_cyc - t0, DIV_LAT + 1);
        chk("t4_first_data",    last_wb_data, 32'hFFFF_FFFA);
        chk("t4_stalled",       stall_cnt - st0, DIV_LAT);
        t0 = last_start_cyc;
        run(12);
        chk("t4_second_lat",  last_wb_cyc - t0, DIV_LAT);
        chk("t4_second_data", last_wb_data, 10);

        // 5: divide into x0 is a NOP; reset mid-divide drops the result.
        w0 = wb_cnt; s0 = start_cnt;
        issue_one(0, 9, 2, 1, 1);
        run(10);
        chk("t5_x0_start", start_cnt - s0, 0);
        chk("t5_x0_wb",    wb_cnt - w0, 0);
        issue_one(9, 1000, 10, 0, 0);
        run(3);
        rst = 1;
        step();
        rst = 0;
        run(12);
        chk("t5_rst_wb",   wb_cnt - w0, 0);
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_rem",  bus.div_rem, 0);

        // 6: divide by zero, fast path or full latency.
        t0 = cyc;
        issue_one(3, 32'h1234, 0, 0, 1);
        run(10);
        chk("t6_rem0_lat",  last_wb_cyc - t0, FAST ? 1 : DIV_LAT);
        chk("t6_rem0_data", last_wb_data, 32'h1234);
        t0 = cyc;
        issue_one(3, 7, 0, 1, 0);
        run(10);
        chk("t6_div0_lat",  last_wb_cyc - t0, FAST ? 1 : DIV_LAT);
        chk("t6_div0_data", last_wb_data, 32'hFFFF_FFFF);

        // Random traffic, model checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            bus.ex_div_req = ($urandom_range(0, 2) == 0);
            bus.ex_flush   = ($urandom_range(0, 7) == 0);
            bus.ex_rd      = 5'($urandom_range(0, 7));
            bus.ex_sign    = 1'($urandom);
            bus.ex_rem     = 1'($urandom);
            bus.ex_op_a    = $urandom;
            bus.ex_op_b    = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
            bus.id_rs1     = 5'($urandom_range(0, 7));
            bus.id_rs2     = 5'($urandom_range(0, 7));
            bus.id_rd      = 5'($urandom_range(0, 7));
            bus.id_rs1_re  = 1'($urandom);
            bus.id_rs2_re  = 1'($urandom);
            bus.id_rd_we   = 1'($urandom);
            bus.pipe_wb_we = ($urandom_range(0, 2) == 0);
            rst            = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 0;
        idle_inputs();
        run(12);
        chk("end_idle", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
